// File: rtl/pasta_pkg.sv
// Shared PASTA constants and the affine-layer state encoding.
package pasta_pkg;

    localparam int BITLEN  = 17;
    localparam int PASTA_S = 32;
    localparam int Q       = 65537;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAT   = 3'd1,
        DRAIN = 3'd2,
        RC    = 3'd3,
        DONE  = 3'd4
    } aff_state_e;

endpackage

// File: rtl/tag_delay_line.sv
// Valid/tag shift register that runs alongside the external modmul pipeline.
module tag_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] tag,
    output logic             valid_dly,
    output logic [WIDTH-1:0] tag_dly,
    output logic             busy
);

    logic [DEPTH-1:0] vld_sr;
    logic [WIDTH-1:0] tag_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= valid;
            tag_sr[0] <= tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign valid_dly = vld_sr[DEPTH-1];
    assign tag_dly   = tag_sr[DEPTH-1];
    assign busy      = |vld_sr;

endmodule

// File: rtl/affine_layer.sv
// PASTA affine layer: out = M*in + rc per half, mod q, using shared external mod units.
// state | meaning
// IDLE  | waiting for start; mod-unit operands held at zero
// MAT   | streaming matrix columns through modmul into the accumulators
// DRAIN | waiting for in-flight products and the last accumulator write
// RC    | adding round constants, results land in out_l / out_r
// DONE  | result valid, done held high until restart or reset
module affine_layer #(
    parameter int MUL_LAT = 3,
    parameter int BITLEN  = pasta_pkg::BITLEN,
    parameter int PASTA_S = pasta_pkg::PASTA_S
) (
    input  logic                      clk,
    input  logic                      rst_aff,
    input  logic                      start,
    input  logic [BITLEN*PASTA_S-1:0] in_l,
    input  logic [BITLEN*PASTA_S-1:0] in_r,
    input  logic [BITLEN*PASTA_S-1:0] col_in,
    input  logic                      col_valid,
    output logic                      col_ready,
    output logic [BITLEN*PASTA_S-1:0] modmul_in1,
    output logic [BITLEN*PASTA_S-1:0] modmul_in2,
    output logic [BITLEN*PASTA_S-1:0] modadd_in1,
    output logic [BITLEN*PASTA_S-1:0] modadd_in2,
    input  logic [BITLEN*PASTA_S-1:0] modmul_out,
    input  logic [BITLEN*PASTA_S-1:0] modadd_out,
    output logic [BITLEN*PASTA_S-1:0] out_l,
    output logic [BITLEN*PASTA_S-1:0] out_r,
    output logic                      done
);

    import pasta_pkg::*;

    localparam int         W             = BITLEN * PASTA_S;
    localparam logic [6:0] HALF_BEATS    = 7'(PASTA_S);
    localparam logic [6:0] BEAT_LAST_MAT = 7'(2 * PASTA_S - 1);
    localparam logic [6:0] BEAT_RC_L     = 7'(2 * PASTA_S);
    localparam logic [6:0] BEAT_RC_R     = 7'(2 * PASTA_S + 1);

    aff_state_e        state;
    aff_state_e        state_nxt;
    logic [6:0]        beat_cnt;
    logic [W-1:0]      x_l;
    logic [W-1:0]      x_r;
    logic [W-1:0]      acc_l;
    logic [W-1:0]      acc_r;
    logic [W-1:0]      x_sel;
    logic [W-1:0]      acc_sel;
    logic [6:0]        x_idx;
    logic [BITLEN-1:0] x_elem;
    logic              mat_beat;
    logic              beat_half;
    logic              col_fire;
    logic              mat_fire;
    logic              restart;
    logic              tag_vld;
    logic              tag_half;
    logic              tag_busy;
    logic              add_pend;
    logic              add_half;
    logic              add_fwd;
    logic              rc_wr_l;
    logic              rc_wr_r;

    assign restart   = start && ((state == IDLE) || (state == DONE));
    assign col_ready = (state == MAT) || ((state == RC) && !rc_wr_r);
    assign col_fire  = col_valid && col_ready;
    assign mat_fire  = col_fire && (state == MAT);
    assign done      = (state == DONE);

    assign mat_beat  = (beat_cnt <= BEAT_LAST_MAT);
    assign beat_half = (beat_cnt >= HALF_BEATS);
    assign x_idx     = !mat_beat ? 7'd0 : (beat_half ? beat_cnt - HALF_BEATS : beat_cnt);
    assign x_sel     = beat_half ? x_r : x_l;
    assign x_elem    = x_sel[x_idx*BITLEN +: BITLEN];

    // The accumulator register lags modadd by one cycle; back-to-back adds into
    // the same half must take the sum straight from modadd_out.
    assign add_fwd   = add_pend && (add_half == tag_half);
    assign acc_sel   = tag_half ? acc_r : acc_l;

    tag_delay_line #(
        .DEPTH (MUL_LAT),
        .WIDTH (1)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst_aff),
        .valid     (mat_fire),
        .tag       (beat_half),
        .valid_dly (tag_vld),
        .tag_dly   (tag_half),
        .busy      (tag_busy)
    );

    always_comb begin
        state_nxt  = state;
        modmul_in1 = '0;
        modmul_in2 = '0;
        modadd_in1 = '0;
        modadd_in2 = '0;
        if (tag_vld) begin
            modadd_in1 = modmul_out;
            modadd_in2 = add_fwd ? modadd_out : acc_sel;
        end
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = MAT;
            end
            MAT: begin
                modmul_in1 = col_in;
                modmul_in2 = {PASTA_S{x_elem}};
                if (col_fire && (beat_cnt == BEAT_LAST_MAT)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!tag_busy && !add_pend) state_nxt = RC;
            end
            RC: begin
                if (col_fire) begin
                    modadd_in1 = (beat_cnt == BEAT_RC_L) ? acc_l : acc_r;
                    modadd_in2 = col_in;
                end
                if (rc_wr_r) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_aff) begin
            state    <= IDLE;
            beat_cnt <= '0;
            x_l      <= '0;
            x_r      <= '0;
            acc_l    <= '0;
            acc_r    <= '0;
            out_l    <= '0;
            out_r    <= '0;
            add_pend <= 1'b0;
            add_half <= 1'b0;
            rc_wr_l  <= 1'b0;
            rc_wr_r  <= 1'b0;
        end else begin
            state    <= state_nxt;
            add_pend <= tag_vld;
            add_half <= tag_half;
            rc_wr_l  <= 1'b0;
            rc_wr_r  <= 1'b0;

            if (add_pend) begin
                if (add_half) acc_r <= modadd_out;
                else          acc_l <= modadd_out;
            end
            if (rc_wr_l) out_l <= modadd_out;
            if (rc_wr_r) out_r <= modadd_out;

            if (restart) begin
                x_l      <= in_l;
                x_r      <= in_r;
                acc_l    <= '0;
                acc_r    <= '0;
                beat_cnt <= '0;
            end else if (col_fire) begin
                if (beat_cnt < BEAT_RC_R) beat_cnt <= beat_cnt + 7'd1;
                if (state == RC) begin
                    if (beat_cnt == BEAT_RC_L) rc_wr_l <= 1'b1;
                    else                       rc_wr_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_affine_layer.sv
// Scoreboard bench for affine_layer with behavioural modmul/modadd lane units.
module tb_affine_layer;

    localparam int MUL_LAT = 3;
    localparam int BL      = pasta_pkg::BITLEN;
    localparam int NS      = pasta_pkg::PASTA_S;
    localparam int W       = BL * NS;
    localparam longint unsigned Q = longint'(pasta_pkg::Q);
    localparam int EXP_LAT = 72;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        bit           chk_lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_aff;
    logic         start;
    logic [W-1:0] in_l;
    logic [W-1:0] in_r;
    logic [W-1:0] col_in;
    logic         col_valid;
    logic         col_ready;
    logic [W-1:0] modmul_in1;
    logic [W-1:0] modmul_in2;
    logic [W-1:0] modadd_in1;
    logic [W-1:0] modadd_in2;
    logic [W-1:0] modmul_out;
    logic [W-1:0] modadd_out;
    logic [W-1:0] out_l;
    logic [W-1:0] out_r;
    logic         done;

    always #5 clk = ~clk;

    affine_layer #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst_aff    (rst_aff),
        .start      (start),
        .in_l       (in_l),
        .in_r       (in_r),
        .col_in     (col_in),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .modmul_in1 (modmul_in1),
        .modmul_in2 (modmul_in2),
        .modadd_in1 (modadd_in1),
        .modadd_in2 (modadd_in2),
        .modmul_out (modmul_out),
        .modadd_out (modadd_out),
        .out_l      (out_l),
        .out_r      (out_r),
        .done       (done)
    );

    function automatic logic [W-1:0] lane_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int j = 0; j < NS; j++) begin
            longint unsigned p;
            p = (longint'(a[j*BL +: BL]) * longint'(b[j*BL +: BL])) % Q;
            r[j*BL +: BL] = BL'(p);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int j = 0; j < NS; j++) begin
            longint unsigned s;
            s = (longint'(a[j*BL +: BL]) + longint'(b[j*BL +: BL])) % Q;
            r[j*BL +: BL] = BL'(s);
        end
        return r;
    endfunction

    // External mod units: modmul is MUL_LAT deep, modadd is one register.
    logic [W-1:0] mm_pipe [MUL_LAT];
    logic [W-1:0] ma_q;
    always @(posedge clk) begin
        if (rst_aff) begin
            for (int i = 0; i < MUL_LAT; i++) mm_pipe[i] <= '0;
            ma_q <= '0;
        end else begin
            mm_pipe[0] <= lane_mul(modmul_in1, modmul_in2);
            for (int i = 1; i < MUL_LAT; i++) mm_pipe[i] <= mm_pipe[i-1];
            ma_q <= lane_add(modadd_in1, modadd_in2);
        end
    end
    assign modmul_out = mm_pipe[MUL_LAT-1];
    assign modadd_out = ma_q;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int unsigned mat [2][NS][NS];
    int unsigned xv  [2][NS];
    int unsigned rc  [2][NS];

    function automatic logic [W-1:0] pack_x(input int h);
        logic [W-1:0] r;
        for (int j = 0; j < NS; j++) r[j*BL +: BL] = BL'(xv[h][j]);
        return r;
    endfunction

    function automatic logic [W-1:0] col_word(input int b);
        logic [W-1:0] r;
        for (int j = 0; j < NS; j++) begin
            if (b < NS)            r[j*BL +: BL] = BL'(mat[0][b][j]);
            else if (b < 2*NS)     r[j*BL +: BL] = BL'(mat[1][b-NS][j]);
            else if (b == 2*NS)    r[j*BL +: BL] = BL'(rc[0][j]);
            else                   r[j*BL +: BL] = BL'(rc[1][j]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] golden(input int h);
        logic [W-1:0] r;
        for (int row = 0; row < NS; row++) begin
            longint unsigned s;
            s = longint'(rc[h][row]) % Q;
            for (int k = 0; k < NS; k++)
                s = (s + (longint'(mat[h][k][row]) * longint'(xv[h][k])) % Q) % Q;
            r[row*BL +: BL] = BL'(s);
        end
        return r;
    endfunction

    // kind: 0 identity, 1 zero matrix with constants, 2 all q-1, 3 random
    task automatic setup(input int kind);
        for (int h = 0; h < 2; h++)
            for (int k = 0; k < NS; k++) begin
                case (kind)
                    0: begin
                        xv[h][k] = (h == 0) ? k : 100 + k;
                        rc[h][k] = 0;
                    end
                    1: begin
                        xv[h][k] = $urandom_range(0, 65536);
                        rc[h][k] = (h == 0) ? 7 : 65536;
                    end
                    2: begin
                        xv[h][k] = 65536;
                        rc[h][k] = 0;
                    end
                    default: begin
                        xv[h][k] = $urandom_range(0, 65536);
                        rc[h][k] = $urandom_range(0, 65536);
                    end
                endcase
                for (int row = 0; row < NS; row++) begin
                    case (kind)
                        0:       mat[h][k][row] = (k == row) ? 1 : 0;
                        1:       mat[h][k][row] = 0;
                        2:       mat[h][k][row] = 65536;
                        default: mat[h][k][row] = $urandom_range(0, 65536);
                    endcase
                end
            end
    endtask

    exp_t sb_q [$];
    exp_t mon_e;
    bit   done_q = 1'b0;
    int   rounds_seen = 0;
    time  t_start = 0;
    time  lat;

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_done", W'(done), W'(0));
            end else begin
                mon_e = sb_q.pop_front();
                lat   = ($time - 5 - t_start) / 10;
                check_eq("out_l", out_l, mon_e.l);
                check_eq("out_r", out_r, mon_e.r);
                check_eq("col_ready_done", W'(col_ready), W'(0));
                if (mon_e.chk_lat) check_eq("done_latency", W'(lat), W'(EXP_LAT));
            end
            rounds_seen++;
        end
        done_q = done;
    end

    task automatic run_round(input bit gaps, input bit chk_lat, input int abort_at, input int poke_at);
        int  target;
        int  cnt;
        bit  rdy;
        bit  fired;
        target = rounds_seen + 1;
        in_l   = pack_x(0);
        in_r   = pack_x(1);
        if (abort_at < 0) sb_q.push_back('{golden(0), golden(1), chk_lat});
        start = 1'b1;
        @(posedge clk);
        t_start = $time;
        #1 start = 1'b0;
        for (int b = 0; b < 2*NS + 2; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    col_valid = 1'b0;
                    col_in    = W'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            col_valid = 1'b1;
            col_in    = col_word(b);
            if (b == poke_at) start = 1'b1;
            cnt   = 0;
            fired = 1'b0;
            rdy   = 1'b0;
            while (!fired && cnt < 300) begin
                @(negedge clk);
                rdy = col_ready;
                @(posedge clk);
                #1;
                fired = rdy;
                cnt++;
            end
            start     = 1'b0;
            col_valid = 1'b0;
            if (!fired) begin
                check_eq("col_ready_wait", W'(rdy), W'(1));
                return;
            end
            if (b == abort_at) begin
                rst_aff = 1'b1;
                @(posedge clk);
                #1 rst_aff = 1'b0;
                return;
            end
        end
        cnt = 0;
        while (rounds_seen < target && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (rounds_seen < target) check_eq("done_wait", W'(done), W'(1));
    endtask

    initial begin
        rst_aff   = 1'b1;
        start     = 1'b0;
        col_valid = 1'b0;
        col_in    = '0;
        in_l      = '0;
        in_r      = '0;
        repeat (3) @(posedge clk);
        #1 rst_aff = 1'b0;
        @(negedge clk);
        check_eq("rst_done", W'(done), W'(0));
        check_eq("rst_col_ready", W'(col_ready), W'(0));
        check_eq("rst_out_l", out_l, '0);
        check_eq("rst_out_r", out_r, '0);
        check_eq("rst_modmul_in1", modmul_in1, '0);
        check_eq("rst_modadd_in1", modadd_in1, '0);

        setup(0); run_round(1'b0, 1'b1, -1, -1);
        setup(1); run_round(1'b0, 1'b1, -1, -1);
        setup(2); run_round(1'b0, 1'b1, -1, -1);
        setup(3); run_round(1'b0, 1'b1, -1, -1);
        run_round(1'b1, 1'b0, -1, -1);

        setup(3); run_round(1'b0, 1'b0, 40, -1);
        @(negedge clk);
        check_eq("abort_done", W'(done), W'(0));
        check_eq("abort_col_ready", W'(col_ready), W'(0));
        check_eq("abort_out_l", out_l, '0);
        check_eq("abort_out_r", out_r, '0);
        check_eq("abort_modmul_in1", modmul_in1, '0);
        setup(3); run_round(1'b0, 1'b1, -1, -1);

        setup(3); run_round(1'b0, 1'b1, -1, 10);
        setup(0); run_round(1'b1, 1'b0, -1, 45);

        check_eq("sb_empty", W'(sb_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/affine_layer.md
AFFINE_LAYER -- requirements
Module: affine_layer

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3: modmul latency in cycles (operands in to result out).
REQ-002 SHALL have parameter BITLEN, default 17: element width; modulus q = 65537.
REQ-003 SHALL have parameter PASTA_S, default 32: elements per half-state.
REQ-004 SHALL have one clock; reset is synchronous and active-high (clk, rst_aff).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_aff  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse; samples in_l/in_r and begins an affine round.
REQ-008 in_l, in_r  in  BITLEN*PASTA_S  left/right state input; element j at bits [17j+16:17j].
REQ-009 col_in  in  BITLEN*PASTA_S  stream word: matrix column or round-constant vector.
REQ-010 col_valid  in  1  col_in valid.
REQ-011 col_ready  out  1  block accepts col_in; beat transfers when valid & ready.
REQ-012 modmul_in1, modmul_in2, modadd_in1, modadd_in2  out  BITLEN*PASTA_S  operands to the shared lane-wise mod units.
REQ-013 modmul_out, modadd_out  in  BITLEN*PASTA_S  results; modadd latency fixed at 1 cycle.
REQ-014 out_l, out_r  out  BITLEN*PASTA_S  registered results, fed to the mix/S-box stage as its in_mc_l/in_mc_r.
REQ-015 done  out  1  level; high from round completion until the next start or reset.

Function
REQ-016 SHALL compute out_l = M_l*in_l + rc_l and out_r = M_r*in_r + rc_r, mod q, lane-wise.
REQ-017 Stream order SHALL be 66 beats: beats 0-31 columns 0-31 of M_l, 32-63 columns of M_r, beat 64 rc_l, beat 65 rc_r.
REQ-018 States SHALL be IDLE, MAT, DRAIN, RC, DONE.
REQ-019 IDLE->MAT on start; acc_l and acc_r cleared to 0 and the input vectors latched in the same cycle.
REQ-020 In MAT, col_ready=1; on beat k, modmul_in1=col_in, modmul_in2 = the element x[k mod 32] of the selected half, replicated to all 32 lanes.
REQ-021 A product SHALL leave modmul MUL_LAT cycles after its beat; a delayed valid/half tag SHALL travel with it through a MUL_LAT-deep shift register.
REQ-022 For each tagged product: modadd_in1=product; modadd_in2=the accumulator of that half, forwarded from modadd_out when the previous cycle added into the same half; modadd_out is written to that accumulator.
REQ-023 col_valid gaps SHALL stall only the beat counter; bubbles in the tag pipe SHALL produce no accumulator write.
REQ-024 MAT->DRAIN after beat 63; col_ready=0 in DRAIN; DRAIN->RC when the tag pipe is empty and the last add has been written.
REQ-025 In RC, col_ready=1; beat 64 drives modadd with acc_l+col_in, and the result is written to out_l; beat 65 does the same with acc_r into out_r.
REQ-026 RC->DONE when the out_r write completes; done=1 in DONE; col_ready=0 outside MAT and RC.
REQ-027 start outside IDLE/DONE SHALL be ignored; start in DONE SHALL restart as in IDLE.
REQ-028 The beat counter SHALL be 7 bits; it saturates at 65 and never wraps within a round.
REQ-029 When idle, the mod-unit operand ports SHALL drive zero.

Reset
REQ-030 rst_aff SHALL force IDLE, clear the beat counter and tag pipe, and set acc_l, acc_r, out_l, out_r to 0, with done=0 and col_ready=0.
REQ-031 Reset mid-round SHALL abort the round; in-flight modmul results SHALL be discarded via the cleared tags; no partial beat is retained.

Structure
REQ-032 BITLEN, PASTA_S, q and the state encoding SHALL live in the shared pasta package used by mix_column_sb.
REQ-033 The MUL_LAT tag shift register SHALL be the sub-module tag_delay_line; modmul/modadd stay external and shared.

Verification
REQ-034 Identity M_l, M_r, zero rcs, in_l[j]=j, in_r[j]=100+j -> out_l=in_l, out_r=in_r, done=1.
REQ-035 Zero matrices, rc_l[j]=7, rc_r[j]=65536 -> out_l all 7, out_r all 65536.
REQ-036 All M entries 65536, all x 65536 -> every out lane = 32 (wrap-around of (-1)(-1) summed).
REQ-037 No stalls, MUL_LAT=3 -> done rises exactly 72 cycles after start; random col_valid gaps -> identical outputs.
REQ-038 rst_aff at beat 40 -> next cycle: IDLE, outputs 0, done=0; a following full round matches the golden model.
REQ-039 start pulsed during MAT -> ignored; result unchanged.
